// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the word-addressed memory responder.
//   - state_t     : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_W      : data/address word width (32)
//   - MASK_W      : byte-lane write-enable width (4)
//   - LATENCY_MAX : largest supported number of wait states (15)
//   - CNT_W       : width of the wait-state counter
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int WORD_W      = 32;
    localparam int MASK_W      = WORD_W / 8;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between the core's memory master and the
//   responder.
//   Request channel : req_valid, req_ready, req_we, req_wmask, req_addr,
//                     req_wdata
//   Response channel: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   Modports: master (core side), slave (responder side).
// -----------------------------------------------------------------------------
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [MASK_W-1:0] req_wmask;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_1rw.sv
// -----------------------------------------------------------------------------
// sram_1rw
//   Synchronous single-port DEPTH x 32 array with per-byte write enable and a
//   registered read port. Contents are not reset.
//   Ports:
//     clk    in  clock
//     en     in  access enable for this cycle
//     we     in  1 = write (lanes selected by wmask), 0 = read
//     wmask  in  byte-lane write enables
//     addr   in  word index
//     wdata  in  write data
//     rdata  out read data, updated only on enabled read cycles
// -----------------------------------------------------------------------------
module sram_1rw
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [MASK_W-1:0] wmask,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // One narrow array per byte lane so each lane maps onto its own block RAM
    // column with a plain write enable.
    genvar gi;
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (wmask[gi]) begin
                            mem[addr] <= wdata[8*gi +: 8];
                        end
                    end else begin
                        rdata_reg <= mem[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Word-addressed memory responder for the MIPS core's load/store and fetch
//   port. Accepts one request at a time, waits LATENCY cycles, then presents
//   read data or a write acknowledgement until the requester takes it.
//   Parameters:
//     DEPTH   : number of 32-bit words (power of two, 2..65536)
//     LATENCY : wait states between acceptance and response (0..15)
//   Ports:
//     clk   in  clock
//     reset in  asynchronous active-low reset
//     bus   slave side of mem_responder_if (request + response channels)
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              LAT_USE = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT_USE);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ready_reg, ready_next;
    logic              rd_ok_reg, rd_ok_next;   // response carries array data
    logic              err_reg, err_next;

    logic              accept;
    logic              in_range;
    logic [WORD_W-1:0] sram_rdata;

    // ready_reg is only ever set when the FSM is heading into IDLE, so it
    // doubles as the "in IDLE" qualifier for acceptance.
    assign accept   = bus.req_valid && ready_reg;

    // Any set bit above the index field means the word lies beyond DEPTH;
    // those bits never reach the array, so there is no aliasing.
    assign in_range = (bus.req_addr[WORD_W-1:AW] == '0);

    // The array is touched only on the acceptance edge: writes commit there
    // and reads sample there, so a read sees the contents before any later
    // write and the read register stays frozen for the whole response.
    sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (accept && in_range),
        .we    (bus.req_we),
        .wmask (bus.req_wmask),
        .addr  (bus.req_addr[AW-1:0]),
        .wdata (bus.req_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            rd_ok_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
            rd_ok_reg <= rd_ok_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_ok_next = rd_ok_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    rd_ok_next = !bus.req_we && in_range;
                    err_next   = !in_range;
                    if (LAT_USE == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

    // Outputs depend only on registered state, never on the request inputs.
    assign bus.req_ready = ready_reg;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_err   = (state_reg == RESP) && err_reg;
    assign bus.rsp_rdata = ((state_reg == RESP) && rd_ok_reg) ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    int          sel;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        rdy_a [4];
    logic        rv_a  [4];
    logic        err_a [4];
    logic [31:0] rd_a  [4];

    int  n_cmp = 0;
    int  n_bad = 0;
    time last_acc_t;

    // Reference memory image per instance, with per-byte "written" flags
    logic [31:0] mdl   [4][1024];
    logic [3:0]  known [4][1024];

    always #5 clk = ~clk;

    function automatic int lat_of(input int s);
        case (s)
            0:       return 0;
            1:       return 2;
            2:       return 5;
            default: return 15;
        endcase
    endfunction

    // Four responders that differ only in LATENCY; sel routes the stimulus.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            mem_responder_if bus ();

            assign bus.req_valid = (sel == gi) ? req_valid : 1'b0;
            assign bus.req_we    = req_we;
            assign bus.req_wmask = req_wmask;
            assign bus.req_addr  = req_addr;
            assign bus.req_wdata = req_wdata;
            assign bus.rsp_ready = (sel == gi) ? rsp_ready : 1'b1;

            mem_responder #(
                .DEPTH   (1024),
                .LATENCY ((gi == 0) ? 0 : (gi == 1) ? 2 : (gi == 2) ? 5 : 15)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus)
            );

            assign rdy_a[gi] = bus.req_ready;
            assign rv_a[gi]  = bus.rsp_valid;
            assign err_a[gi] = bus.rsp_err;
            assign rd_a[gi]  = bus.rsp_rdata;
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void mdl_write(input int s, input logic [31:0] a,
                                      input logic [3:0] m, input logic [31:0] d);
        if (a < 1024) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) begin
                    mdl[s][a[9:0]][8*b +: 8] = d[8*b +: 8];
                    known[s][a[9:0]][b]      = 1'b1;
                end
            end
        end
    endfunction

    // One complete transaction; called and returns on a falling edge.
    task automatic do_txn(input int s, input logic we, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d, input int bp,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int waited;
        int lat;
        waited    = 0;
        sel       = s;
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = (bp == 0);
        while (!rdy_a[s] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy_a[s]) begin
            chk({tag, " accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            return;
        end
        @(posedge clk);
        last_acc_t = $time;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " busy_ready"}, 32'(rdy_a[s]), 32'd0);
        lat = 1;
        while (!rv_a[s] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(lat_of(s) + 1));
        if (!rv_a[s]) begin
            rsp_ready = 1'b1;
            return;
        end
        chk({tag, " rdata"}, rd_a[s], exp_rd);
        chk({tag, " err"}, 32'(err_a[s]), 32'(exp_err));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, 32'(rv_a[s]), 32'd1);
            chk({tag, " hold_rdata"}, rd_a[s], exp_rd);
            chk({tag, " hold_err"}, 32'(err_a[s]), 32'(exp_err));
            chk({tag, " hold_ready"}, 32'(rdy_a[s]), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " post_valid"}, 32'(rv_a[s]), 32'd0);
        chk({tag, " post_ready"}, 32'(rdy_a[s]), 32'd1);
        $display("txn %s: lat%0d we=%0d addr=%h mask=%h wdata=%h exp_rdata=%h exp_err=%0d latency=%0d",
                 tag, lat_of(s), we, a, m, d, exp_rd, exp_err, lat);
    endtask

    typedef struct {
        int          s;
        logic        we;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        int          bp;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [15];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        time t0, t1, t2;
        bit  saw_valid;

        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 1024; w++) known[s][w] = 4'h0;

        //        sel we  mask   addr           wdata         bp exp_rdata     err
        vt[0]  = '{1, 1, 4'hF, 32'd5,         32'hDEADBEEF, 0, 32'h0,        1'b0};
        vt[1]  = '{1, 0, 4'hF, 32'd5,         32'h0,        0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1, 1, 4'hF, 32'd7,         32'h11223344, 0, 32'h0,        1'b0};
        vt[3]  = '{1, 1, 4'h5, 32'd7,         32'hAABBCCDD, 0, 32'h0,        1'b0};
        vt[4]  = '{1, 0, 4'hF, 32'd7,         32'h0,        0, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1, 1, 4'hF, 32'd0,         32'hCAFEF00D, 0, 32'h0,        1'b0};
        vt[6]  = '{1, 1, 4'hF, 32'd1024,      32'h55555555, 0, 32'h0,        1'b1};
        vt[7]  = '{1, 0, 4'hF, 32'd1024,      32'h0,        0, 32'h0,        1'b1};
        vt[8]  = '{1, 0, 4'hF, 32'd0,         32'h0,        0, 32'hCAFEF00D, 1'b0};
        vt[9]  = '{1, 1, 4'hF, 32'h8000_0000, 32'h12121212, 1, 32'h0,        1'b1};
        vt[10] = '{1, 0, 4'hF, 32'd0,         32'h0,        0, 32'hCAFEF00D, 1'b0};
        vt[11] = '{1, 1, 4'h0, 32'd5,         32'h00000000, 0, 32'h0,        1'b0};
        vt[12] = '{1, 0, 4'hF, 32'd5,         32'h0,        2, 32'hDEADBEEF, 1'b0};
        vt[13] = '{0, 1, 4'hF, 32'd5,         32'h0BADF00D, 0, 32'h0,        1'b0};
        vt[14] = '{0, 0, 4'hF, 32'd5,         32'h0,        4, 32'h0BADF00D, 1'b0};

        // Reset state
        reset     = 1'b0;
        sel       = 0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk("reset_req_ready", 32'(rdy_a[s]), 32'd0);
            chk("reset_rsp_valid", 32'(rv_a[s]), 32'd0);
            chk("reset_rsp_rdata", rd_a[s], 32'd0);
            chk("reset_rsp_err", 32'(err_a[s]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) chk("release_req_ready", 32'(rdy_a[s]), 32'd1);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            do_txn(vt[i].s, vt[i].we, vt[i].m, vt[i].a, vt[i].d, vt[i].bp,
                   vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));
            if (vt[i].we) mdl_write(vt[i].s, vt[i].a, vt[i].m, vt[i].d);
        end

        // Reset during WAIT (LATENCY=5): the write stays, the response is dropped
        sel       = 2;
        req_we    = 1'b1;
        req_wmask = 4'hF;
        req_addr  = 32'd3;
        req_wdata = 32'h12345678;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        chk("rst_mid pre_ready", 32'(rdy_a[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid async_valid", 32'(rv_a[2]), 32'd0);
        chk("rst_mid async_ready", 32'(rdy_a[2]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid recover_ready", 32'(rdy_a[2]), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rv_a[2]) saw_valid = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid no_response", 32'(saw_valid), 32'd0);
        $display("txn rst_mid: lat5 write addr 3 aborted by reset");
        mdl_write(2, 32'd3, 4'hF, 32'h12345678);
        do_txn(2, 1'b0, 4'hF, 32'd3, 32'h0, 0, 32'h12345678, 1'b0, "rst_mid_read");

        // Back-to-back reads at LATENCY=15
        do_txn(3, 1'b1, 4'hF, 32'd1, 32'hA1A1A1A1, 0, 32'h0, 1'b0, "b2b_w1");
        mdl_write(3, 32'd1, 4'hF, 32'hA1A1A1A1);
        do_txn(3, 1'b1, 4'hF, 32'd2, 32'hB2B2B2B2, 0, 32'h0, 1'b0, "b2b_w2");
        mdl_write(3, 32'd2, 4'hF, 32'hB2B2B2B2);
        do_txn(3, 1'b0, 4'hF, 32'd1, 32'h0, 0, 32'hA1A1A1A1, 1'b0, "b2b_r1");
        t0 = last_acc_t;
        do_txn(3, 1'b0, 4'hF, 32'd2, 32'h0, 0, 32'hB2B2B2B2, 1'b0, "b2b_r2");
        t1 = last_acc_t;
        do_txn(3, 1'b0, 4'hF, 32'd1, 32'h0, 0, 32'hA1A1A1A1, 1'b0, "b2b_r3");
        t2 = last_acc_t;
        chk("b2b spacing1", 32'((t1 - t0) / 10), 32'd17);
        chk("b2b spacing2", 32'((t2 - t1) / 10), 32'd17);

        // Randomized traffic against the reference image
        for (int i = 0; i < 80; i++) begin
            int          s;
            int          pick;
            logic        we;
            logic [3:0]  m;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] er;
            logic        ee;
            s    = $urandom_range(0, 3);
            we   = 1'($urandom_range(0, 1));
            m    = 4'($urandom);
            d    = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = 32'd1024 + 32'($urandom_range(0, 5000));
            else if (pick == 1) a = $urandom | 32'h0001_0000;
            else                a = 32'($urandom_range(0, 15));
            if (!we && a < 1024 && known[s][a[9:0]] != 4'hF) we = 1'b1;
            ee = (a >= 1024);
            er = (!we && !ee) ? mdl[s][a[9:0]] : 32'h0;
            do_txn(s, we, m, a, d, $urandom_range(0, 3), er, ee, $sformatf("rand%0d", i));
            if (we) mdl_write(s, a, m, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder serving the load/store and fetch port of the MIPS core. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and returns read data or a write acknowledgement over a second valid/ready handshake. It sits between the core's memory-request master and an on-chip SRAM array. Addresses are word indices, matching the core's PC increment of 1 per instruction.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two, 2..65536.
- LATENCY, 2: wait states between acceptance and response, 0..15.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_wmask  in  4  byte-lane write enable; bit i covers data bits [8i+7:8i].
- req_addr  in  32  word address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range (req_addr >= DEPTH).

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1. Accept on req_valid&&req_ready.
  - If LATENCY==0, go to RESP. Otherwise go to WAIT and load cnt=LATENCY.
- WAIT: req_ready=0. cnt decrements each cycle. At cnt==1, go to RESP.
- RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- On acceptance, capture we, addr, wmask, wdata, and the range flag.
  - In-range write: commits to the array on the acceptance edge, only in lanes with wmask set. wmask=0 is a legal no-op that is still acknowledged.
  - Read: samples the array on the acceptance edge, so it returns the pre-write contents.
  - Out-of-range access: no array write, rdata=0, rsp_err=1.
- Only one outstanding transaction is allowed. Request inputs are ignored outside IDLE.
- Address bits above log2(DEPTH) participate only in the range check and never alias.
- The array contents are not reset. Reading a never-written word returns X in simulation; the bench must not depend on it.

## Timing
- Reset values: req_ready=0 while reset is low, then 1 from the first cycle after release; rsp_valid=0; rsp_rdata=0; rsp_err=0; cnt=0.
- Acceptance at edge k: rsp_valid rises after edge k+LATENCY+1−1. For LATENCY=0, that is the cycle right after edge k.
- Request-to-response latency is LATENCY+1 cycles, measured from the acceptance edge to the first edge at which rsp_valid is sampled high.
- Response held under backpressure: rsp_valid, rsp_rdata and rsp_err stay constant for any number of rsp_ready=0 cycles.
- There is always one IDLE cycle after each response handshake. Peak throughput is one transaction per LATENCY+2 cycles.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the response is dropped.
  - A write accepted before the reset remains committed.
  - No response is ever produced for the aborted request.
- All outputs are driven from registers or the FSM state. There is no combinational path from req_* or rsp_ready to any output.

## Structure
- Package mem_responder_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the LATENCY_MAX=15 constant;
  - the word width constant of 32 and the mask width of 4.
- Sub-module sram_1rw: synchronous single-port array, DEPTH×32, with per-byte write enable and registered read.
  - The responder instantiates it once and drives it only on the acceptance cycle.

## Test plan
- Write then read, LATENCY=2: write addr 5, data 0xDEADBEEF, mask 0xF, then read addr 5. Each rsp_valid appears 3 cycles after acceptance. The read returns 0xDEADBEEF with rsp_err=0; the write response has rsp_rdata=0.
- Byte masking: write 0x11223344 to addr 7, then write 0xAABBCCDD with mask 0x5, then read addr 7. The read returns 0x11BB33DD.
- Backpressure, LATENCY=0: read addr 5 with rsp_ready held low for 4 cycles. rsp_valid stays high from the first cycle after acceptance and data stays stable. req_ready=0 throughout and returns to 1 one cycle after the handshake.
- Out of range, DEPTH=1024: write to addr 1024, then read addr 1024. Both responses have rsp_err=1 and rdata=0. A read of addr 0 afterwards is unaffected.
- Reset mid-WAIT, LATENCY=5: accept a write to addr 3 (0x12345678), then pull reset low 2 cycles later. No rsp_valid appears and req_ready recovers to 1. A later read of addr 3 returns 0x12345678.
- Back-to-back, LATENCY=15: issue 3 reads with rsp_ready=1. Acceptances are spaced exactly 17 cycles apart.
